// File: rtl/traffic_pkg.sv
// Shared types for the intersection lamp interface: phases, per-approach lamp
// codes, monitor states and fault codes.
package traffic_pkg;

    typedef enum logic [1:0] {
        NSG_EWR = 2'd0,
        NSY_EWR = 2'd1,
        NSR_EWG = 2'd2,
        NSR_EWY = 2'd3
    } phase_e;

    typedef enum logic [1:0] {
        LAMP_R       = 2'd0,
        LAMP_Y       = 2'd1,
        LAMP_G       = 2'd2,
        LAMP_INVALID = 2'd3
    } lamp_e;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } mon_state_e;

    localparam logic [2:0] FC_NONE        = 3'd0;
    localparam logic [2:0] FC_CONFLICT    = 3'd1;
    localparam logic [2:0] FC_INVALID     = 3'd2;
    localparam logic [2:0] FC_SEQUENCE    = 3'd3;
    localparam logic [2:0] FC_SHORT_GREEN = 3'd4;
    localparam logic [2:0] FC_SHORT_YEL   = 3'd5;
    localparam logic [2:0] FC_WATCHDOG    = 3'd6;

    // Phases advance 0->1->2->3->0; the 2-bit wrap gives the 3->0 step.
    function automatic phase_e next_phase(phase_e p);
        return phase_e'(p + 2'd1);
    endfunction

endpackage

// File: rtl/lamp_decode.sv
// Maps one approach's red/yellow/green drives to a lamp code; any pattern
// other than exactly one lamp lit is INVALID.
module lamp_decode
    import traffic_pkg::*;
(
    input  logic       red_i,
    input  logic       yellow_i,
    input  logic       green_i,
    output logic [1:0] code_o
);

    always_comb begin
        case ({red_i, yellow_i, green_i})
            3'b100:  code_o = LAMP_R;
            3'b010:  code_o = LAMP_Y;
            3'b001:  code_o = LAMP_G;
            default: code_o = LAMP_INVALID;
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Safety monitor for the lamp interface: samples the six drives, tracks the
// phase, and latches a sticky fault code with a flashing-red request.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned MIN_GREEN     = 25_000_000,
    parameter int unsigned MIN_YELLOW    = 5_000_000,
    parameter int unsigned MAX_PHASE     = 100_000_000,
    parameter int unsigned GLITCH_CYCLES = 16,
    parameter int unsigned FLASH_HALF    = 25_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        red_ns,
    input  logic        yellow_ns,
    input  logic        green_ns,
    input  logic        red_ew,
    input  logic        yellow_ew,
    input  logic        green_ew,
    input  logic        clear_fault,
    output logic        fault,
    output logic [2:0]  fault_code,
    output logic [1:0]  phase,
    output logic        phase_valid,
    output logic        flash_red,
    output logic [15:0] cycle_count
);

    localparam int GW = $clog2(GLITCH_CYCLES + 1);
    localparam int FW = $clog2(FLASH_HALF + 1);
    localparam logic [GW-1:0] GLITCH_MAX = GW'(GLITCH_CYCLES);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);

    logic [5:0]    lamps_q;
    mon_state_e    state_q;
    phase_e        phase_q, dec_phase;
    logic [31:0]   cnt_q, cnt_d;
    logic [GW-1:0] glitch_q, glitch_d;
    logic [FW-1:0] flash_cnt_q;
    logic          exempt_q, fault_q, flash_q, valid_q;
    logic [2:0]    code_q, pat_code, viol_code;
    logic [15:0]   cycles_q;
    logic [1:0]    ns_code, ew_code;
    logic          pat_valid, conflict, glitch_hit, is_trans, legal;

    lamp_decode u_dec_ns (
        .red_i    (lamps_q[5]),
        .yellow_i (lamps_q[4]),
        .green_i  (lamps_q[3]),
        .code_o   (ns_code)
    );

    lamp_decode u_dec_ew (
        .red_i    (lamps_q[2]),
        .yellow_i (lamps_q[1]),
        .green_i  (lamps_q[0]),
        .code_o   (ew_code)
    );

    always_comb begin
        conflict  = (lamps_q[4] | lamps_q[3]) & (lamps_q[1] | lamps_q[0]);
        pat_valid = 1'b1;
        dec_phase = NSG_EWR;
        if      (ns_code == LAMP_G && ew_code == LAMP_R) dec_phase = NSG_EWR;
        else if (ns_code == LAMP_Y && ew_code == LAMP_R) dec_phase = NSY_EWR;
        else if (ns_code == LAMP_R && ew_code == LAMP_G) dec_phase = NSR_EWG;
        else if (ns_code == LAMP_R && ew_code == LAMP_Y) dec_phase = NSR_EWY;
        else                                             pat_valid = 1'b0;

        // Saturating run length of non-phase samples
        if (pat_valid)                    glitch_d = '0;
        else if (glitch_q == GLITCH_MAX)  glitch_d = glitch_q;
        else                              glitch_d = glitch_q + GW'(1);
        glitch_hit = (glitch_d == GLITCH_MAX);

        is_trans = (state_q == ST_RUN) && pat_valid && (dec_phase != phase_q);
        legal    = (dec_phase == next_phase(phase_q));

        if ((state_q == ST_INIT && pat_valid) || is_trans) cnt_d = 32'd1;
        else if (cnt_q == '1)                              cnt_d = cnt_q;
        else                                               cnt_d = cnt_q + 32'd1;

        // Pattern checks stay live in FAULT so they can override a clear
        pat_code  = conflict ? FC_CONFLICT : (glitch_hit ? FC_INVALID : FC_NONE);
        viol_code = pat_code;
        if (viol_code == FC_NONE) begin
            if (is_trans && !legal)
                viol_code = FC_SEQUENCE;
            else if (is_trans && !exempt_q && !phase_q[0] && cnt_q < MIN_GREEN)
                viol_code = FC_SHORT_GREEN;
            else if (is_trans && !exempt_q && phase_q[0] && cnt_q < MIN_YELLOW)
                viol_code = FC_SHORT_YEL;
            else if (cnt_d >= MAX_PHASE)
                viol_code = FC_WATCHDOG;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lamps_q     <= '0;
            state_q     <= ST_INIT;
            phase_q     <= NSG_EWR;
            cnt_q       <= '0;
            glitch_q    <= '0;
            flash_cnt_q <= '0;
            exempt_q    <= 1'b0;
            fault_q     <= 1'b0;
            flash_q     <= 1'b0;
            valid_q     <= 1'b0;
            code_q      <= FC_NONE;
            cycles_q    <= '0;
        end else begin
            lamps_q  <= {red_ns, yellow_ns, green_ns, red_ew, yellow_ew, green_ew};
            glitch_q <= glitch_d;
            case (state_q)
                ST_INIT, ST_RUN: begin
                    if (viol_code != FC_NONE) begin
                        state_q     <= ST_FAULT;
                        fault_q     <= 1'b1;
                        code_q      <= viol_code;
                        flash_q     <= 1'b1;
                        flash_cnt_q <= '0;
                        valid_q     <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                        if (state_q == ST_INIT && pat_valid) begin
                            state_q  <= ST_RUN;
                            phase_q  <= dec_phase;
                            exempt_q <= 1'b1;
                            valid_q  <= 1'b1;
                        end else if (is_trans) begin
                            phase_q  <= dec_phase;
                            exempt_q <= 1'b0;
                            if (phase_q == NSR_EWY) cycles_q <= cycles_q + 16'd1;
                        end
                    end
                end
                ST_FAULT: begin
                    if (clear_fault && pat_code != FC_NONE) begin
                        code_q      <= pat_code;
                        flash_q     <= 1'b1;
                        flash_cnt_q <= '0;
                    end else if (clear_fault) begin
                        state_q     <= ST_INIT;
                        fault_q     <= 1'b0;
                        code_q      <= FC_NONE;
                        flash_q     <= 1'b0;
                        flash_cnt_q <= '0;
                        cnt_q       <= '0;
                        glitch_q    <= '0;
                        exempt_q    <= 1'b0;
                    end else if (flash_cnt_q == FLASH_LAST) begin
                        flash_q     <= ~flash_q;
                        flash_cnt_q <= '0;
                    end else begin
                        flash_cnt_q <= flash_cnt_q + FW'(1);
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign fault       = fault_q;
    assign fault_code  = code_q;
    assign phase       = phase_q;
    assign phase_valid = valid_q;
    assign flash_red   = flash_q;
    assign cycle_count = cycles_q;

endmodule
